// File: rtl/uart_rx_byte_fifo.sv
// UART byte sink: parity check, 16-deep FWFT FIFO, sticky overflow and saturating parity-error count.
// A write shows on dout_* one cycle later; dout_ready=0 holds the head, and a write into a full FIFO is dropped unless a pop frees a slot that cycle.
module uart_rx_byte_fifo #(
  parameter bit PARITY_ODD = 1'b0,
  parameter bit DROP_BAD   = 1'b0,
  parameter int ADDR_W     = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Rx_Done,
  input  logic [7:0]        data_byte,
  input  logic              check1,
  input  logic              flush,
  input  logic              clear_err,
  input  logic              dout_ready,
  output logic              dout_valid,
  output logic [7:0]        dout_data,
  output logic              dout_perr,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic [15:0]       perr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef struct packed {
    logic       perr;
    logic [7:0] dat;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         perr_cnt_q, perr_cnt_d;

  logic perr;
  logic wr_req;
  logic pop;
  logic full;
  logic do_wr;

  always_comb begin
    perr   = Rx_Done & (((^data_byte) ^ PARITY_ODD) != check1);
    wr_req = Rx_Done & ~(DROP_BAD & perr);
    full   = (count_q == CNT_FULL);
    pop    = dout_valid & dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    do_wr  = wr_req & (~full | pop) & ~flush;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = clear_err ? 1'b0 : overflow_q;
    perr_cnt_d = clear_err ? 16'd0 : perr_cnt_q;

    if (perr && perr_cnt_d != 16'hFFFF) begin
      perr_cnt_d = perr_cnt_d + 16'd1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = '{perr: perr, dat: data_byte};
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_wr && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !do_wr) begin
        count_d = count_q - CNT_ONE;
      end
      if (wr_req && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      perr_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  always_comb begin
    dout_valid = (count_q != '0);
    dout_data  = mem_q[rd_ptr_q].dat;
    dout_perr  = mem_q[rd_ptr_q].perr;
    fifo_count = count_q;
    overflow   = overflow_q;
    perr_cnt   = perr_cnt_q;
  end

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Scoreboard bench for uart_rx_byte_fifo: random and directed byte streams against a queue-based reference.
module tb_uart_rx_byte_fifo;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Rx_Done;
  logic [7:0]  data_byte;
  logic        check1;
  logic        flush;
  logic        clear_err;
  logic        dout_ready;
  logic        dout_valid;
  logic [7:0]  dout_data;
  logic        dout_perr;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [15:0] perr_cnt;

  logic        drop_valid;
  logic [7:0]  drop_data;
  logic        drop_perr;
  logic [4:0]  drop_count;
  logic        drop_overflow;
  logic [15:0] drop_perr_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       perr;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  bit   m_ovf;
  int   m_perr;

  always #5 Clk = ~Clk;

  uart_rx_byte_fifo dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rx_Done(Rx_Done), .data_byte(data_byte), .check1(check1),
    .flush(flush), .clear_err(clear_err), .dout_ready(dout_ready), .dout_valid(dout_valid),
    .dout_data(dout_data), .dout_perr(dout_perr), .fifo_count(fifo_count),
    .overflow(overflow), .perr_cnt(perr_cnt)
  );

  uart_rx_byte_fifo #(.DROP_BAD(1'b1)) dut_drop (
    .Clk(Clk), .Rst_n(Rst_n), .Rx_Done(Rx_Done), .data_byte(data_byte), .check1(check1),
    .flush(flush), .clear_err(clear_err), .dout_ready(dout_ready), .dout_valid(drop_valid),
    .dout_data(drop_data), .dout_perr(drop_perr), .fifo_count(drop_count),
    .overflow(drop_overflow), .perr_cnt(drop_perr_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Even parity: the correct parity bit is the count of ones modulo 2.
  function automatic logic good_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Reference model and monitor: compare the visible state, then advance the model.
  always @(negedge Clk) begin
    int  sz;
    bit  bad;
    bit  take;
    if (!Rst_n) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_perr = 0;
    end
    chk("valid", dout_valid, exp_q.size() != 0);
    chk("count", fifo_count, exp_q.size());
    chk("overflow", overflow, m_ovf);
    chk("perr_cnt", perr_cnt, m_perr);
    if (exp_q.size() != 0) begin
      chk("head_data", dout_data, exp_q[0].dat);
      chk("head_perr", dout_perr, exp_q[0].perr);
    end
    if (drop_valid) chk("drop_head_perr", drop_perr, 0);
    if (Rst_n) begin
      sz   = exp_q.size();
      bad  = Rx_Done && (check1 != good_par(data_byte));
      take = (sz > 0) && dout_ready;
      if (clear_err) begin
        m_ovf  = 1'b0;
        m_perr = 0;
      end
      if (bad && m_perr < 65535) m_perr++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (take) void'(exp_q.pop_front());
        if (Rx_Done) begin
          if (sz == 16 && !take) m_ovf = 1'b1;
          else exp_q.push_back('{perr: bad, dat: data_byte});
        end
      end
    end
  end

  task automatic step(input bit rx, input logic [7:0] d, input bit bad, input bit rdy,
                      input bit fl = 1'b0, input bit clr = 1'b0);
    Rx_Done    = rx;
    data_byte  = d;
    check1     = good_par(d) ^ bad;
    dout_ready = rdy;
    flush      = fl;
    clear_err  = clr;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int nw;
    Rst_n = 1'b0; Rx_Done = 1'b0; data_byte = '0; check1 = 1'b0;
    flush = 1'b0; clear_err = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", dout_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", dout_data, 0);
    Rst_n = 1'b1;
    step(0, 8'h00, 0, 0);

    // 1: good byte, visible next cycle, then popped
    step(1, 8'hA5, 0, 1);
    chk("t1_valid", dout_valid, 1);
    chk("t1_data", dout_data, 8'hA5);
    chk("t1_perr", dout_perr, 0);
    step(0, 8'h00, 0, 1);
    chk("t1_count", fifo_count, 0);

    // 2: parity error, stored here but dropped by the DROP_BAD instance
    step(1, 8'h01, 1, 0);
    chk("t2_perr", dout_perr, 1);
    chk("t2_perr_cnt", perr_cnt, 1);
    chk("t2_drop_count", drop_count, 0);
    chk("t2_drop_perr_cnt", drop_perr_cnt, 1);
    step(0, 8'h00, 0, 1);

    // 3: fill, overflow on the 17th, drain in order
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("t3_full_count", fifo_count, 16);
    chk("t3_no_ovf", overflow, 0);
    step(1, 8'h10, 0, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_count_held", fifo_count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", dout_data, i);
      step(0, 8'h00, 0, 1);
    end
    step(0, 8'h00, 0, 0, 0, 1);
    chk("t3_clr_ovf", overflow, 0);

    // 4: write and pop together while full
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("t4_head", dout_data, 8'h00);
    step(1, 8'h55, 0, 1);
    chk("t4_count", fifo_count, 16);
    chk("t4_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain", dout_data, (i < 15) ? i + 1 : 8'h55);
      step(0, 8'h00, 0, 1);
    end

    // 5: random traffic across pointer wrap
    nw = 0;
    while (nw < 40) begin
      bit rx;
      rx = 1'($urandom_range(0, 1));
      step(rx, 8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      if (rx) nw++;
    end
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 1);
    chk("t5_drained", fifo_count, 0);

    // 5b: saturate the parity-error counter while flushing each byte away
    step(0, 8'h00, 0, 0, 0, 1);
    repeat (65535) step(1, 8'h01, 1, 0, 1, 0);
    chk("t5_sat", perr_cnt, 16'hFFFF);
    step(1, 8'h03, 1, 0);
    chk("t5_sat_hold", perr_cnt, 16'hFFFF);
    step(0, 8'h00, 0, 1);

    // 6: flush with a coincident byte, clear with a coincident bad byte, async reset
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'hC3, 0, 0, 1, 0);
    chk("t6_flush_count", fifo_count, 0);
    chk("t6_flush_valid", dout_valid, 0);
    step(1, 8'h07, 1, 0, 0, 1);
    chk("t6_clr_perr", perr_cnt, 1);
    for (int i = 0; i < 17; i++) step(1, 8'(8'h80 + i), 0, 0);
    chk("t6_pre_rst_ovf", overflow, 1);
    #1 Rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_data", dout_data, 0);
    chk("t6_rst_perr", dout_perr, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_perr_cnt", perr_cnt, 0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    step(1, 8'h3C, 0, 0);
    chk("t6_post_rst_data", dout_data, 8'h3C);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
